multi_cross_bar: RTL
====================

MULTI_CROSS_BAR -- requirements
Module: multi_cross_bar

Interface
REQ-001 SHALL have parameter NM, default 4, number of masters (2..8).
REQ-002 SHALL have parameter NS, default 2, number of slaves (power of 2, 2..8).
REQ-003 SHALL have parameter AW, default 32, address width.
REQ-004 SHALL have parameter DW, default 32, data width.
REQ-005 SHALL have parameter ARB_MODE, default 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest master index wins).
REQ-006 SHALL have port clk, input, 1, clock, rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port req, input, NM, per-master request.
REQ-009 SHALL have port addr, input, NM*AW, master m address at [m*AW +: AW].
REQ-010 SHALL have port cmd, input, NM, per-master command: 1 = write, 0 = read.
REQ-011 SHALL have port wdata, input, NM*DW, master m write data at [m*DW +: DW].
REQ-012 SHALL have port ack, output, NM, per-master one-cycle acknowledge.
REQ-013 SHALL have port rdata, output, NM*DW, per-master read data.
REQ-014 SHALL have port slv_req, output, NS, per-slave request.
REQ-015 SHALL have ports slv_addr (NS*AW), slv_cmd (NS) and slv_wdata (NS*DW), all outputs, carrying the forwarded request fields per slave.
REQ-016 SHALL have ports slv_ack (NS) and slv_rdata (NS*DW), both inputs, carrying the per-slave acknowledge and read data.

Function
REQ-017 Target slave of master m SHALL be addr[m][AW-1 -: log2(NS)].
REQ-018 Masters SHALL hold req/addr/cmd/wdata stable from req rise until ack; a violation SHALL be ignored (the transaction in flight completes with the originally latched fields).
REQ-019 Each slave SHALL own an independent FSM with states IDLE, BUSY and RESP; distinct slaves SHALL serve distinct masters concurrently.
REQ-020 IDLE->BUSY SHALL occur at the first edge where at least one master has req=1 targeting this slave; at that same edge the winner's addr/cmd/wdata SHALL be registered onto slv_addr/slv_cmd/slv_wdata and slv_req SHALL be set to 1.
REQ-021 In BUSY the slave outputs SHALL hold; on slv_ack=1 the FSM SHALL go to RESP and slv_req SHALL clear at the same edge.
REQ-022 On that same edge, ack[g] SHALL be set to 1 for the granted master g and rdata[g] SHALL be loaded with slv_rdata, regardless of cmd.
REQ-023 RESP->IDLE SHALL be unconditional after one cycle, and ack[g] SHALL return to 0 on that edge; the RESP cycle gives the master one cycle to drop or change req before re-arbitration.
REQ-024 rdata[m] SHALL hold its last value except when loaded per REQ-022.
REQ-025 Latency: req sampled at edge E gives slv_req=1 after E; slv_ack sampled at edge K gives ack=1 after K; minimum master-to-master turnaround SHALL be 3 cycles.
REQ-026 Round-robin arbitration SHALL use a per-slave pointer ptr: search masters ptr, ptr+1, ... wrapping modulo NM; the first requester wins and ptr SHALL be set to (winner+1) mod NM on grant.
REQ-027 With ARB_MODE=1, ptr SHALL be unused and the lowest-index requester SHALL win.
REQ-028 A slv_ack arriving while the slave FSM is IDLE or RESP SHALL be ignored.
REQ-029 A master SHALL never be granted by two slaves at once.

Reset
REQ-030 While reset=1 (asynchronous): all FSMs SHALL be IDLE, all ptr SHALL be 0, and ack, rdata, slv_req, slv_addr, slv_cmd and slv_wdata SHALL all be 0.
REQ-031 Reset mid-transaction SHALL abort it with no ack generated; after release, a still-asserted req SHALL be re-arbitrated normally.

Verification (NM=4, NS=2, AW=DW=32)
REQ-032 Single read: m0 req with addr=0x0000_0010, cmd=0; slave0 acks 2 cycles after slv_req with rdata=0xDEAD_BEEF -> slv_addr0=0x10 one edge after req; ack[0] pulses 1 cycle; rdata[0]=0xDEAD_BEEF.
REQ-033 Parallel: m1 to addr 0x0000_0004 and m2 to addr 0x8000_0004 asserted in the same cycle -> slv_req0 and slv_req1 rise on the same edge; each master is acked independently.
REQ-034 Round-robin contention: m0..m3 all continuously request slave0, slave acks each in 1 cycle -> grant order 0,1,2,3,0 with a 3-cycle spacing between grants.
REQ-035 Fixed priority (ARB_MODE=1), same stimulus -> m0 is granted every transaction and m1..m3 starve.
REQ-036 Reset asserted in BUSY -> slv_req and ack are 0 immediately; no ack pulse is produced; re-grant occurs on the first edge after release.
REQ-037 Spurious slv_ack in IDLE -> no ack output and no change to rdata.

Source files
------------

// File: rtl/multi_cross_bar.sv
// ============================================================================
// Module   : multi_cross_bar
// Brief    : NM-master / NS-slave request/acknowledge crossbar. Each slave
//            port has its own IDLE/BUSY/RESP engine and arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_cross_bar #(
    parameter int NM       = 4,
    parameter int NS       = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int ARB_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NM-1:0]    req,
    input  logic [NM*AW-1:0] addr,
    input  logic [NM-1:0]    cmd,
    input  logic [NM*DW-1:0] wdata,
    output logic [NM-1:0]    ack,
    output logic [NM*DW-1:0] rdata,
    output logic [NS-1:0]    slv_req,
    output logic [NS*AW-1:0] slv_addr,
    output logic [NS-1:0]    slv_cmd,
    output logic [NS*DW-1:0] slv_wdata,
    input  logic [NS-1:0]    slv_ack,
    input  logic [NS*DW-1:0] slv_rdata
);

    localparam int MW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = $clog2(NS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    logic [NM*SW-1:0] target;
    logic [NS-1:0]    done;
    logic [NS*MW-1:0] grant_all;
    logic [NS*NM-1:0] owned_all;
    logic [NM-1:0]    owned_any;

    for (genvar m = 0; m < NM; m++) begin : g_target
        assign target[m*SW +: SW] = addr[m*AW + AW - 1 -: SW];
    end

    // A master held by any slave (BUSY or RESP) is invisible to every arbiter,
    // so a master that changes its address mid-flight cannot be double-granted.
    always_comb begin
        owned_any = '0;
        for (int s = 0; s < NS; s++) begin
            owned_any = owned_any | owned_all[s*NM +: NM];
        end
    end

    for (genvar s = 0; s < NS; s++) begin : g_slave
        state_t          state;
        state_t          next_state;
        logic [MW-1:0]   ptr;
        logic [MW-1:0]   grant;
        logic [MW-1:0]   winner;
        logic [MW:0]     slot;
        logic            found;
        logic [NM-1:0]   cand;
        logic            req_r;
        logic [AW-1:0]   addr_r;
        logic            cmd_r;
        logic [DW-1:0]   wdata_r;

        always_comb begin
            cand = '0;
            for (int m = 0; m < NM; m++) begin
                cand[m] = req[m] && (target[m*SW +: SW] == SW'(s)) && !owned_any[m];
            end
        end

        // Search order starts at ptr (round-robin) or at 0 (fixed priority).
        always_comb begin
            slot   = '0;
            found  = 1'b0;
            winner = '0;
            for (int i = 0; i < NM; i++) begin
                if (ARB_MODE == 0) begin
                    slot = {1'b0, ptr} + (MW+1)'(i);
                end else begin
                    slot = (MW+1)'(i);
                end
                if (slot >= (MW+1)'(NM)) begin
                    slot = slot - (MW+1)'(NM);
                end
                if (!found && cand[slot[MW-1:0]]) begin
                    found  = 1'b1;
                    winner = slot[MW-1:0];
                end
            end
        end

        always_comb begin
            next_state = state;
            case (state)
                IDLE:    if (found)      next_state = BUSY;
                BUSY:    if (slv_ack[s]) next_state = RESP;
                RESP:                    next_state = IDLE;
                default:                 next_state = IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state   <= IDLE;
                ptr     <= '0;
                grant   <= '0;
                req_r   <= 1'b0;
                addr_r  <= '0;
                cmd_r   <= 1'b0;
                wdata_r <= '0;
            end else begin
                state <= next_state;
                if (state == IDLE && found) begin
                    grant   <= winner;
                    req_r   <= 1'b1;
                    addr_r  <= addr[winner*AW +: AW];
                    cmd_r   <= cmd[winner];
                    wdata_r <= wdata[winner*DW +: DW];
                    if (ARB_MODE == 0) begin
                        ptr <= (winner == MW'(NM-1)) ? '0 : winner + 1'b1;
                    end
                end else if (state == BUSY && slv_ack[s]) begin
                    req_r <= 1'b0;
                end
            end
        end

        assign done[s]                = (state == BUSY) && slv_ack[s];
        assign grant_all[s*MW +: MW]  = grant;
        assign owned_all[s*NM +: NM]  = (state != IDLE) ? (NM'(1) << grant) : '0;
        assign slv_req[s]             = req_r;
        assign slv_addr[s*AW +: AW]   = addr_r;
        assign slv_cmd[s]             = cmd_r;
        assign slv_wdata[s*DW +: DW]  = wdata_r;
    end

    // ack lives exactly one cycle: set on the BUSY->RESP edge, cleared on the next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack   <= '0;
            rdata <= '0;
        end else begin
            ack <= '0;
            for (int s = 0; s < NS; s++) begin
                for (int m = 0; m < NM; m++) begin
                    if (done[s] && grant_all[s*MW +: MW] == MW'(m)) begin
                        ack[m]            <= 1'b1;
                        rdata[m*DW +: DW] <= slv_rdata[s*DW +: DW];
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
